// File: rtl/spart_pkg.sv
// rtl/spart_pkg.sv - shared types and widths for the SPART program writer
package spart_pkg;

    localparam int ADDR_W = 16;
    localparam int DATA_W = 16;

    typedef enum logic [2:0] {
        IDLE,
        CNT_HI,
        DAT_LO,
        DAT_HI,
        CHK
    } wr_state_t;

endpackage

// File: rtl/spart_byte_timer.sv
// rtl/spart_byte_timer.sv - inter-byte timeout counter for the program writer
module spart_byte_timer #(
    parameter int TIMEOUT = 50000
) (
    input  logic clk,
    input  logic rst,
    input  logic clr,
    input  logic run,
    output logic expired
);

    localparam int CNT_W = $clog2(TIMEOUT + 1);

    logic [CNT_W-1:0] count_q;
    logic [CNT_W-1:0] count_d;

    // Fires on the cycle the idle gap reaches TIMEOUT clocks; a byte arriving that cycle wins.
    assign expired = run && !clr && (count_q == CNT_W'(TIMEOUT - 1));

    // Count idle cycles only inside a frame; any received byte restarts the gap.
    always_comb begin
        count_d = count_q;
        if (clr || !run || expired) begin
            count_d = '0;
        end else begin
            count_d = count_q + CNT_W'(1);
        end
    end

    // Counter register.
    always_ff @(posedge clk) begin
        if (rst) begin
            count_q <= '0;
        end else begin
            count_q <= count_d;
        end
    end

endmodule

// File: rtl/spart_prog_writer.sv
// rtl/spart_prog_writer.sv - boot frame parser feeding program_loader; SPART_PROG_CHKSUM_EN adds XOR trailer check
module spart_prog_writer
    import spart_pkg::*;
#(
    parameter logic [ADDR_W-1:0] BASE_ADDR = 16'h0000,
    parameter int                DEPTH     = 1024,
    parameter int                TIMEOUT   = 50000
) (
    input  logic              clk,
    input  logic              rst,
    input  logic [7:0]        rx_data,
    input  logic              rx_valid,
    output logic [ADDR_W-1:0] mem_addr,
    output logic [DATA_W-1:0] mem_data,
    output logic              mem_wr,
    output logic              mem_en,
    output logic              cpu_hold,
    output logic              load_done,
    output logic              err_len,
`ifdef SPART_PROG_CHKSUM_EN
    output logic              err_chk,
`endif
    output logic              err_tmo
);

    localparam logic [16:0] DEPTH_L = 17'(DEPTH);

    wr_state_t         state_q, state_d;
    logic [7:0]        cnt_lo_q, cnt_lo_d;
    logic [15:0]       n_q, n_d;
    logic [15:0]       idx_q, idx_d;
    logic [7:0]        lo_q, lo_d;
    logic              fin_q, fin_d;
    logic [ADDR_W-1:0] mem_addr_q, mem_addr_d;
    logic [DATA_W-1:0] mem_data_q, mem_data_d;
    logic              mem_wr_q, mem_wr_d;
    logic              cpu_hold_q, cpu_hold_d;
    logic              load_done_q, load_done_d;
    logic              err_len_q, err_len_d;
    logic              err_tmo_q, err_tmo_d;
`ifdef SPART_PROG_CHKSUM_EN
    logic [7:0]        xor_q, xor_d;
    logic              err_chk_q, err_chk_d;
`endif

    logic        tmo_expired;
    logic [15:0] n_rx;

    assign n_rx = {rx_data, cnt_lo_q};

    spart_byte_timer #(
        .TIMEOUT (TIMEOUT)
    ) u_timer (
        .clk     (clk),
        .rst     (rst),
        .clr     (rx_valid),
        .run     (state_q != IDLE),
        .expired (tmo_expired)
    );

    // Frame parser: next state, word assembly and strobe generation.
    always_comb begin
        state_d     = state_q;
        cnt_lo_d    = cnt_lo_q;
        n_d         = n_q;
        idx_d       = idx_q;
        lo_d        = lo_q;
        fin_d       = 1'b0;
        mem_addr_d  = mem_addr_q;
        mem_data_d  = mem_data_q;
        mem_wr_d    = 1'b0;
        cpu_hold_d  = cpu_hold_q;
        load_done_d = 1'b0;
        err_len_d   = err_len_q;
        err_tmo_d   = 1'b0;
`ifdef SPART_PROG_CHKSUM_EN
        xor_d       = xor_q;
        err_chk_d   = 1'b0;
`endif

        // The last word's write cycle has just been presented; finish one clock later.
        // A new frame starting in this same cycle re-asserts cpu_hold below.
        if (fin_q) begin
            load_done_d = 1'b1;
            cpu_hold_d  = 1'b0;
        end

        if (tmo_expired) begin
            err_tmo_d  = 1'b1;
            cpu_hold_d = 1'b0;
            state_d    = IDLE;
        end else if (rx_valid) begin
`ifdef SPART_PROG_CHKSUM_EN
            xor_d = xor_q ^ rx_data;
`endif
            case (state_q)
                IDLE: begin
                    cnt_lo_d   = rx_data;
                    cpu_hold_d = 1'b1;
                    err_len_d  = 1'b0;
                    idx_d      = '0;
`ifdef SPART_PROG_CHKSUM_EN
                    xor_d      = rx_data;
`endif
                    state_d    = CNT_HI;
                end
                CNT_HI: begin
                    n_d = n_rx;
                    if ({1'b0, n_rx} > DEPTH_L) begin
                        err_len_d = 1'b1;
                    end
                    if (n_rx == 16'd0) begin
`ifdef SPART_PROG_CHKSUM_EN
                        state_d     = CHK;
`else
                        load_done_d = 1'b1;
                        cpu_hold_d  = 1'b0;
                        state_d     = IDLE;
`endif
                    end else begin
                        state_d = DAT_LO;
                    end
                end
                DAT_LO: begin
                    lo_d    = rx_data;
                    state_d = DAT_HI;
                end
                DAT_HI: begin
                    mem_data_d = {rx_data, lo_q};
                    mem_addr_d = BASE_ADDR + idx_q;
                    mem_wr_d   = ({1'b0, idx_q} < DEPTH_L);
                    idx_d      = idx_q + 16'd1;
                    if (idx_q + 16'd1 == n_q) begin
`ifdef SPART_PROG_CHKSUM_EN
                        state_d = CHK;
`else
                        fin_d   = 1'b1;
                        state_d = IDLE;
`endif
                    end else begin
                        state_d = DAT_LO;
                    end
                end
`ifdef SPART_PROG_CHKSUM_EN
                CHK: begin
                    cpu_hold_d = 1'b0;
                    state_d    = IDLE;
                    if (rx_data == xor_q) begin
                        load_done_d = 1'b1;
                    end else begin
                        err_chk_d = 1'b1;
                    end
                end
`endif
                default: begin
                    state_d = IDLE;
                end
            endcase
        end
    end

    // All state and outputs are registered; reset returns everything to zero / IDLE.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q     <= IDLE;
            cnt_lo_q    <= '0;
            n_q         <= '0;
            idx_q       <= '0;
            lo_q        <= '0;
            fin_q       <= 1'b0;
            mem_addr_q  <= '0;
            mem_data_q  <= '0;
            mem_wr_q    <= 1'b0;
            cpu_hold_q  <= 1'b0;
            load_done_q <= 1'b0;
            err_len_q   <= 1'b0;
            err_tmo_q   <= 1'b0;
`ifdef SPART_PROG_CHKSUM_EN
            xor_q       <= '0;
            err_chk_q   <= 1'b0;
`endif
        end else begin
            state_q     <= state_d;
            cnt_lo_q    <= cnt_lo_d;
            n_q         <= n_d;
            idx_q       <= idx_d;
            lo_q        <= lo_d;
            fin_q       <= fin_d;
            mem_addr_q  <= mem_addr_d;
            mem_data_q  <= mem_data_d;
            mem_wr_q    <= mem_wr_d;
            cpu_hold_q  <= cpu_hold_d;
            load_done_q <= load_done_d;
            err_len_q   <= err_len_d;
            err_tmo_q   <= err_tmo_d;
`ifdef SPART_PROG_CHKSUM_EN
            xor_q       <= xor_d;
            err_chk_q   <= err_chk_d;
`endif
        end
    end

    assign mem_addr  = mem_addr_q;
    assign mem_data  = mem_data_q;
    assign mem_wr    = mem_wr_q;
    assign mem_en    = mem_wr_q;
    assign cpu_hold  = cpu_hold_q;
    assign load_done = load_done_q;
    assign err_len   = err_len_q;
    assign err_tmo   = err_tmo_q;
`ifdef SPART_PROG_CHKSUM_EN
    assign err_chk   = err_chk_q;
`endif

endmodule

// File: tb/tb_spart_prog_writer.sv
// tb/tb_spart_prog_writer.sv - self-checking bench for spart_prog_writer (honours SPART_PROG_CHKSUM_EN)
module tb_spart_prog_writer;

    localparam logic [15:0] BASE    = 16'h0000;
    localparam int          DEPTH   = 2;
    localparam int          TIMEOUT = 100;

    logic        clk = 1'b0;
    logic        rst;
    logic [7:0]  rx_data;
    logic        rx_valid;
    logic [15:0] mem_addr;
    logic [15:0] mem_data;
    logic        mem_wr;
    logic        mem_en;
    logic        cpu_hold;
    logic        load_done;
    logic        err_len;
    logic        err_tmo;
    logic        err_chk;

    int checks = 0;
    int errors = 0;
    int cyc    = 0;

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    spart_prog_writer #(
        .BASE_ADDR (BASE),
        .DEPTH     (DEPTH),
        .TIMEOUT   (TIMEOUT)
    ) dut (
        .clk       (clk),
        .rst       (rst),
        .rx_data   (rx_data),
        .rx_valid  (rx_valid),
        .mem_addr  (mem_addr),
        .mem_data  (mem_data),
        .mem_wr    (mem_wr),
        .mem_en    (mem_en),
        .cpu_hold  (cpu_hold),
        .load_done (load_done),
        .err_len   (err_len),
`ifdef SPART_PROG_CHKSUM_EN
        .err_chk   (err_chk),
`endif
        .err_tmo   (err_tmo)
    );

`ifndef SPART_PROG_CHKSUM_EN
    assign err_chk = 1'b0;
`endif

    // Observed events, sampled away from the active edge.
    logic [15:0] wr_addr[$];
    logic [15:0] wr_data[$];
    int          wr_cyc[$];
    int          done_cyc[$];
    int          tmo_cyc[$];
    int          chk_cyc[$];
    int          en_bad;

    always @(negedge clk) begin
        if (mem_wr === 1'b1) begin
            wr_addr.push_back(mem_addr);
            wr_data.push_back(mem_data);
            wr_cyc.push_back(cyc);
        end
        if (load_done === 1'b1) done_cyc.push_back(cyc);
        if (err_tmo === 1'b1) tmo_cyc.push_back(cyc);
        if (err_chk === 1'b1) chk_cyc.push_back(cyc);
        if (mem_en !== mem_wr) en_bad = en_bad + 1;
    end

    task automatic clear_obs();
        wr_addr.delete(); wr_data.delete(); wr_cyc.delete();
        done_cyc.delete(); tmo_cyc.delete(); chk_cyc.delete();
        en_bad = 0;
    endtask

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic send_byte(input logic [7:0] b, output int strobe);
        rx_data  = b;
        rx_valid = 1'b1;
        strobe   = cyc;
        @(negedge clk);
        rx_valid = 1'b0;
    endtask

    // Words of the frame under test; the count is words.size().
    logic [15:0] words[$];

    // Sends one complete frame and compares every observation against the frame rules.
    task automatic do_frame(input string tag, input bit corrupt, input int max_gap);
        logic [7:0] fb[$];
        int         strobes[$];
        int         s, n, nwr, exp_done_cyc;
        logic [7:0] x;
        bit         exp_done;
        n = words.size();
        fb.push_back(8'(n));
        fb.push_back(8'(n >> 8));
        foreach (words[i]) begin
            fb.push_back(words[i][7:0]);
            fb.push_back(words[i][15:8]);
        end
`ifdef SPART_PROG_CHKSUM_EN
        x = 8'h00;
        foreach (fb[i]) x = x ^ fb[i];
        fb.push_back(corrupt ? (x ^ 8'h01) : x);
`else
        x = 8'h00;
`endif
        clear_obs();
        foreach (fb[i]) begin
            if (i == fb.size() - 1) chk({tag, " hold_in_frame"}, {31'd0, cpu_hold}, 32'd1);
            send_byte(fb[i], s);
            strobes.push_back(s);
            repeat ($urandom_range(0, max_gap)) @(negedge clk);
        end
        repeat (4) @(negedge clk);

        nwr = (n < DEPTH) ? n : DEPTH;
        chk({tag, " wr_count"}, wr_addr.size(), nwr);
        for (int i = 0; i < nwr && i < wr_addr.size(); i++) begin
            chk({tag, " wr_addr"}, wr_addr[i], 32'(BASE + 16'(i)));
            chk({tag, " wr_data"}, wr_data[i], words[i]);
            chk({tag, " wr_latency"}, wr_cyc[i], strobes[3 + 2 * i] + 1);
        end
`ifdef SPART_PROG_CHKSUM_EN
        exp_done     = !corrupt;
        exp_done_cyc = strobes[strobes.size() - 1] + 1;
        chk({tag, " err_chk_count"}, chk_cyc.size(), corrupt ? 1 : 0);
`else
        exp_done     = 1'b1;
        exp_done_cyc = (n == 0) ? strobes[1] + 1 : strobes[2 * n + 1] + 2;
`endif
        chk({tag, " done_count"}, done_cyc.size(), exp_done ? 1 : 0);
        if (exp_done && done_cyc.size() > 0) chk({tag, " done_cyc"}, done_cyc[0], exp_done_cyc);
        chk({tag, " err_len"}, {31'd0, err_len}, (n > DEPTH) ? 1 : 0);
        chk({tag, " hold_after"}, {31'd0, cpu_hold}, 32'd0);
        chk({tag, " tmo_count"}, tmo_cyc.size(), 32'd0);
        chk({tag, " en_eq_wr"}, en_bad, 32'd0);
    endtask

    initial begin
        int s, waited;
        rst      = 1'b1;
        rx_valid = 1'b0;
        rx_data  = 8'h00;
        en_bad   = 0;
        repeat (3) @(negedge clk);
        chk("reset_outs", {mem_addr, mem_data}, 32'd0);
        chk("reset_flags", {26'd0, mem_wr, mem_en, cpu_hold, load_done, err_len, err_tmo}, 32'd0);
        rst = 1'b0;
        @(negedge clk);

        // Two-word frame, back-to-back and spaced bytes.
        words = '{16'h1234, 16'h5678};
        do_frame("two_words", 1'b0, 0);
        do_frame("two_words_gap", 1'b0, 2);

        // Empty frame.
        words.delete();
        do_frame("empty", 1'b0, 1);

        // More words than DEPTH.
        words = '{16'h1111, 16'h2222, 16'h3333};
        do_frame("over_depth", 1'b0, 1);

        // Inter-byte timeout mid-frame.
        clear_obs();
        send_byte(8'h02, s);
        send_byte(8'h00, s);
        send_byte(8'h34, s);
        waited = 0;
        while (tmo_cyc.size() == 0 && waited < TIMEOUT + 20) begin
            @(negedge clk);
            waited++;
        end
        chk("tmo_seen", tmo_cyc.size(), 32'd1);
        if (tmo_cyc.size() > 0) chk("tmo_cyc", tmo_cyc[0], s + TIMEOUT + 1);
        chk("tmo_hold", {31'd0, cpu_hold}, 32'd0);
        chk("tmo_no_done", done_cyc.size(), 32'd0);
        @(negedge clk);
        chk("tmo_one_pulse", tmo_cyc.size(), 32'd1);
        words = '{16'h1234, 16'h5678};
        do_frame("after_tmo", 1'b0, 1);

        // Reset between LO and HI bytes.
        clear_obs();
        send_byte(8'h01, s);
        send_byte(8'h00, s);
        send_byte(8'hCD, s);
        rst = 1'b1;
        @(negedge clk);
        chk("midrst_flags", {26'd0, mem_wr, mem_en, cpu_hold, load_done, err_len, err_tmo}, 32'd0);
        chk("midrst_outs", {mem_addr, mem_data}, 32'd0);
        rst = 1'b0;
        @(negedge clk);
        words = '{16'hABCD};
        do_frame("after_rst", 1'b0, 0);

`ifdef SPART_PROG_CHKSUM_EN
        words = '{16'hABCD};
        do_frame("chk_bad", 1'b1, 0);
`endif

        // Randomised frames.
        for (int f = 0; f < 10; f++) begin
            int nw;
            bit bad;
            nw = $urandom_range(0, 4);
            words.delete();
            for (int i = 0; i < nw; i++) words.push_back(16'($urandom));
`ifdef SPART_PROG_CHKSUM_EN
            bad = 1'($urandom_range(0, 1));
`else
            bad = 1'b0;
`endif
            do_frame($sformatf("rand%0d", f), bad, 2);
        end

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
